// File: rtl/hop_arbiter.sv
// Round-robin arbiter for N_REQ requesters sharing one registered data hop.
// Define HOP_ARBITER_TIMEOUT_EN to compile in the MAX_HOLD grant timeout and requester mask.
module hop_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         i,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     o
);

  localparam int unsigned IdW = $clog2(N_REQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic             o_q, o_d;

  logic [N_REQ-1:0] eligible;
  logic [IdW-1:0]   winner;
  logic [IdW-1:0]   cand;
  logic             found;

`ifdef HOP_ARBITER_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] mask_q, mask_d;

  // A timed-out requester stays ineligible until it lets go of its request.
  assign eligible = req & ~mask_q;
`else
  logic [7:0] unused_max_hold;

  assign unused_max_hold = 8'(MAX_HOLD);
  assign eligible        = req;
`endif

  // First eligible index at or after the pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IdW'((32'(ptr_q) + k) % N_REQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    o_d      = 1'b0;
`ifdef HOP_ARBITER_TIMEOUT_EN
    cnt_d    = cnt_q;
    mask_d   = mask_q & req;
`endif
    unique case (state_q)
      StIdle: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        if (found) begin
          state_d  = StGrant;
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          gnt_id_d = winner;
          ptr_d    = (winner == IdW'(N_REQ - 1)) ? '0 : winner + 1'b1;
          o_d      = i[winner];
`ifdef HOP_ARBITER_TIMEOUT_EN
          cnt_d    = 8'd1;
`endif
        end
      end
      StGrant: begin
        if (!req[gnt_id_q]) begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
`ifdef HOP_ARBITER_TIMEOUT_EN
        else if (cnt_q == 8'(MAX_HOLD)) begin
          state_d          = StIdle;
          gnt_d            = '0;
          gnt_id_d         = '0;
          mask_d[gnt_id_q] = 1'b1;
        end
`endif
        else begin
          o_d   = i[gnt_id_q];
`ifdef HOP_ARBITER_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      o_q      <= 1'b0;
`ifdef HOP_ARBITER_TIMEOUT_EN
      cnt_q    <= '0;
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      o_q      <= o_d;
`ifdef HOP_ARBITER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == StGrant);
  assign o      = o_q;

endmodule

// File: tb/tb_hop_arbiter.sv
// Self-checking bench for hop_arbiter: reference model compared every cycle plus directed
// literal expectations.
module tb_hop_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] i;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         o;

  int n_total = 0;
  int n_pass  = 0;

  hop_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .i      (i),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .o      (o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: owner index (-1 when idle), rotating pointer, hold count, masked set.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_hold  = 0;
  logic [N-1:0] m_mask  = '0;
  logic         m_o     = 1'b0;
  bit           m_live  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_mask  = '0;
      m_o     = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_mask = m_mask & req;
      if (m_owner < 0) begin
        m_o = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_owner < 0 && req[c] && !m_mask[c]) begin
            m_owner = c;
            m_ptr   = (c + 1) % N;
            m_hold  = 1;
            m_o     = i[c];
          end
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
        m_o     = 1'b0;
      end
`ifdef HOP_ARBITER_TIMEOUT_EN
      else if (m_hold >= MH) begin
        m_mask[m_owner] = 1'b1;
        m_owner         = -1;
        m_o             = 1'b0;
      end
`endif
      else begin
        m_hold = m_hold + 1;
        m_o    = i[m_owner];
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [N-1:0] e_gnt;
      logic [1:0]   e_id;
      e_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
      e_id  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      n_total++;
      if (gnt === e_gnt && gnt_id === e_id && busy === (m_owner >= 0) && o === m_o)
        n_pass++;
      else
        $display("FAIL model t=%0t got gnt=%b id=%0d busy=%b o=%b want gnt=%b id=%0d busy=%b o=%b",
                 $time, gnt, gnt_id, busy, o, e_gnt, e_id, (m_owner >= 0), m_o);
      n_total++;
      if ($countones(gnt) <= 1) n_pass++;
      else $display("FAIL onehot t=%0t got gnt=%b want at most one bit", $time, gnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    i   = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_o", 32'(o), 32'h0);
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_o", 32'(o), 32'h0);
    end

    // Single requester with data toggling through the hop.
    req = 4'b0100;
    i   = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_o1", 32'(o), 32'h1);
    i = 4'b0000;
    tick();
    chk("single_o0", 32'(o), 32'h0);
    chk("single_hold", 32'(gnt), 32'h4);
    i = 4'b0100;
    tick();
    chk("single_o1b", 32'(o), 32'h1);
    req = 4'b0000;
    tick();
    chk("single_drop_gnt", 32'(gnt), 32'h0);
    chk("single_drop_o", 32'(o), 32'h0);
    chk("single_drop_busy", 32'(busy), 32'h0);

    // Pointer at zero, simultaneous requests 1 and 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    i   = 4'b0000;
    tick();
    chk("ptr0_gnt", 32'(gnt), 32'h2);
    chk("ptr0_id", 32'(gnt_id), 32'h1);
    req = 4'b0000;
    tick();

    // Fairness: all requesting, each grantee drops after two cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    i   = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt_a", 32'(gnt), 32'(1 << (k % 4)));
      tick();
      chk("rr_gnt_b", 32'(gnt), 32'(1 << (k % 4)));
      req[k % 4] = 1'b0;
      tick();
      chk("rr_gap", 32'(gnt), 32'h0);
      req = 4'b1111;
    end

    // Reset in the middle of a grant.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1000;
    i   = 4'b1000;
    tick();
    chk("mid_gnt3", 32'(gnt), 32'h8);
    chk("mid_o", 32'(o), 32'h1);
    rst = 1'b1;
    req = 4'b1001;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_o", 32'(o), 32'h0);
    chk("mid_rst_id", 32'(gnt_id), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_after_gnt", 32'(gnt), 32'h1);
    chk("mid_after_o", 32'(o), 32'h0);
    req = 4'b0000;
    tick();

    // Two requesters held high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    i   = 4'b0011;
`ifdef HOP_ARBITER_TIMEOUT_EN
    repeat (MH) begin
      tick();
      chk("to_gnt0", 32'(gnt), 32'h1);
    end
    tick();
    chk("to_gap", 32'(gnt), 32'h0);
    repeat (MH) begin
      tick();
      chk("to_gnt1", 32'(gnt), 32'h2);
    end
    repeat (3) begin
      tick();
      chk("to_masked", 32'(gnt), 32'h0);
    end
    req = 4'b0010;
    tick();
    chk("to_unmask_idle", 32'(gnt), 32'h0);
    req = 4'b0011;
    tick();
    chk("to_regrant0", 32'(gnt), 32'h1);
`else
    repeat (50) begin
      tick();
      chk("hold_gnt0", 32'(gnt), 32'h1);
    end
`endif
    req = 4'b0000;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
